// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl: VGA sync timing generator with pixel-clock divider,
// coordinate outputs, a sync/blank delay line matched to the pixel
// generator's latency, and a registered colour output stage.
module vga_display_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 4,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int IN_BITS    = 1,
  parameter int COLOR_BITS = 4,
  parameter int PIPE       = 0,
  parameter int CW         = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    pixel_tick,
  output logic [CW-1:0]           pixel_x,
  output logic [CW-1:0]           pixel_y,
  output logic                    video_on,
  output logic                    frame_start,
  output logic                    line_start,
  input  logic [3*IN_BITS-1:0]    rgb_in,
  output logic                    hsync,
  output logic                    vsync,
  output logic [3*COLOR_BITS-1:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON    = 1'(HSYNC_POL);
  localparam logic          VS_ON    = 1'(VSYNC_POL);

  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic [CW-1:0]           h_cnt_q, h_cnt_d;
  logic [CW-1:0]           v_cnt_q, v_cnt_d;
  logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    tick;
  logic                    hs_raw, vs_raw;
  logic [2:0]              cur_flags;   // {video_on, hs_raw, vs_raw}
  logic [2:0]              dly_flags;   // cur_flags delayed by PIPE ticks
  logic [3*COLOR_BITS-1:0] rgb_exp;

  // Divider and sync/blank decode from the counter registers.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    // Gated by reset so that CLK_DIV=1 does not show a tick while held in reset.
    tick      = (div_cnt_q == DIV_LAST) && !reset;
    video_on  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw    = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    vs_raw    = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    cur_flags = {video_on, hs_raw, vs_raw};
  end

  // Horizontal/vertical counters advance on the pixel tick.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  // Widen each channel by repeating its bit pattern MSB-first, then truncating.
  always_comb begin
    rgb_exp = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      for (int unsigned k = 0; k < COLOR_BITS; k++) begin
        rgb_exp[ch*COLOR_BITS + COLOR_BITS - 1 - k] =
          rgb_in[ch*IN_BITS + IN_BITS - 1 - (k % IN_BITS)];
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign dly_flags = cur_flags;
    end else begin : g_pipe
      logic [2:0] stage_q [PIPE];
      logic [2:0] stage_d [PIPE];

      // Shift the flag pipeline one stage per pixel tick.
      always_comb begin
        stage_d = stage_q;
        if (tick) begin
          stage_d[0] = cur_flags;
          for (int unsigned i = 1; i < PIPE; i++) stage_d[i] = stage_q[i-1];
        end
      end

      // Flag pipeline registers; cleared stages read as blank, syncs inactive.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < PIPE; i++) stage_q[i] <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dly_flags = stage_q[PIPE-1];
    end
  endgenerate

  // Output stage loads blanked colour and polarity-adjusted syncs on the tick.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (tick) begin
      rgb_d   = dly_flags[2] ? rgb_exp : '0;
      hsync_d = dly_flags[1] ? HS_ON : ~HS_ON;
      vsync_d = dly_flags[0] ? VS_ON : ~VS_ON;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      rgb_q     <= '0;
      hsync_q   <= ~HS_ON;
      vsync_q   <= ~VS_ON;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign pixel_tick  = tick;
  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign frame_start = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign line_start  = tick && (h_cnt_q == '0);
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Testbench for vga_display_ctrl: small timing, PIPE=2, 3->4 bit colour,
// active-high vsync; random colour input checked against a tick-count model.
module tb_vga_display_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int CD = 4,  HP = 0, VP = 1;
  localparam int IB = 3,  CB = 4, PP = 2, CW = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic              clock = 1'b0;
  logic              reset;
  logic              pixel_tick;
  logic [CW-1:0]     pixel_x, pixel_y;
  logic              video_on, frame_start, line_start;
  logic [3*IB-1:0]   rgb_in;
  logic              hsync, vsync;
  logic [3*CB-1:0]   rgb;

  int passed = 0;
  int total  = 0;
  int k;          // clock edges since reset release
  int tick_rgb;   // colour input presented on the most recent tick

  vga_display_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .HSYNC_POL(HP), .VSYNC_POL(VP),
    .IN_BITS(IB), .COLOR_BITS(CB), .PIPE(PP), .CW(CW)
  ) dut (
    .clock(clock), .reset(reset), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_start(frame_start), .line_start(line_start),
    .rgb_in(rgb_in), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  // Repeat the IB-bit pattern of each channel until it covers CB bits, keep the top CB.
  function automatic int expand(input int v);
    int res = 0;
    for (int ch = 2; ch >= 0; ch--) begin
      int c    = (v >> (ch * IB)) & ((1 << IB) - 1);
      int reps = (CB + IB - 1) / IB;
      int acc  = 0;
      for (int r = 0; r < reps; r++) acc = (acc << IB) | c;
      acc = acc >> (reps * IB - CB);
      res = (res << CB) | acc;
    end
    return res;
  endfunction

  // Compare every output with the model for the current edge count k, then drive new colour.
  task automatic check_cycle();
    int n, x, y, src, sx, sy;
    bit t, vis, hs_in, vs_in;
    n = k / CD;
    t = (k % CD) == (CD - 1);
    x = n % HT;
    y = (n / HT) % VT;
    chk("pixel_tick",  pixel_tick,  t);
    chk("pixel_x",     pixel_x,     x);
    chk("pixel_y",     pixel_y,     y);
    chk("video_on",    video_on,    (x < HA) && (y < VA));
    chk("frame_start", frame_start, t && x == 0 && y == 0);
    chk("line_start",  line_start,  t && x == 0);
    src = n - 1 - PP;
    if (src < 0) begin
      chk("rgb_blank",   rgb,   0);
      chk("hsync_idle",  hsync, 1 - HP);
      chk("vsync_idle",  vsync, 1 - VP);
    end else begin
      sx    = src % HT;
      sy    = (src / HT) % VT;
      vis   = (sx < HA) && (sy < VA);
      hs_in = (sx >= HA + HF) && (sx < HA + HF + HS);
      vs_in = (sy >= VA + VF) && (sy < VA + VF + VS);
      chk("rgb",   rgb,   vis ? expand(tick_rgb) : 0);
      chk("hsync", hsync, hs_in ? HP : 1 - HP);
      chk("vsync", vsync, vs_in ? VP : 1 - VP);
    end
    rgb_in = 9'($urandom_range(0, (1 << (3 * IB)) - 1));
    if (t) tick_rgb = int'(rgb_in);
  endtask

  task automatic step();
    check_cycle();
    @(negedge clock);
    k++;
  endtask

  initial begin
    int guard;
    k        = 0;
    tick_rgb = 0;
    reset    = 1'b1;
    rgb_in   = '0;
    repeat (3) @(negedge clock);
    chk("rst_rgb",   rgb,        0);
    chk("rst_hsync", hsync,      1 - HP);
    chk("rst_vsync", vsync,      1 - VP);
    chk("rst_x",     pixel_x,    0);
    chk("rst_y",     pixel_y,    0);
    chk("rst_tick",  pixel_tick, 0);

    // Two full frames plus a little, covering both wraps and repeated frame_start.
    reset = 1'b0;
    k = 0;
    repeat (2 * HT * VT * CD + 40) step();

    // Advance to a mid-frame point, then hit reset between clock edges.
    guard = 0;
    while (!(((k / CD) % HT) == 10 && (((k / CD) / HT) % VT) == 3 && (k % CD) == 1)
           && guard < HT * VT * CD + 10) begin
      step();
      guard++;
    end
    chk("midframe_reached", guard < HT * VT * CD + 10, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rgb",   rgb,        0);
    chk("mid_rst_hsync", hsync,      1 - HP);
    chk("mid_rst_vsync", vsync,      1 - VP);
    chk("mid_rst_x",     pixel_x,    0);
    chk("mid_rst_y",     pixel_y,    0);
    chk("mid_rst_tick",  pixel_tick, 0);
    @(negedge clock);
    @(negedge clock);
    chk("mid_hold_x",    pixel_x,    0);
    reset = 1'b0;
    k = 0;
    repeat (HT * VT * CD + 60) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
